// File: rtl/sram_pkg.sv
// sram_pkg -- shared definitions for the SRAM responder.
//   sram_state_e   : responder FSM state encoding (idle / wait / respond)
//   LATENCY_MIN/MAX: legal range of the response latency parameter
//   CNT_W          : width of the latency down-counter
//   is_misaligned  : true when a byte address is not word aligned
package sram_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } sram_state_e;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 7;
    localparam int unsigned CNT_W       = 3;

    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if -- CPU-side request/response bus of the SRAM responder.
//   req, req_we, req_addr, req_wdata : request from the CPU (master drives)
//   req_ready                        : responder can accept this cycle
//   resp_valid, resp_rdata, resp_err : one-cycle response pulse (slave drives)
interface sram_responder_if;

    logic        req;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/sram_array.sv
// sram_array -- 2^ADDR_W x 32 storage, single address port.
//   clk   : clock
//   we    : byte write enables (byte i = wdata[8i+7:8i])
//   re    : read enable; rdata is registered on the same edge
//   idx   : word index
//   wdata : write data
//   rdata : registered read data
// Contents are never reset.
module sram_array #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic              re,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1 << ADDR_W) - 1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// sram_responder -- fixed-latency single-outstanding SRAM responder.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset (storage is retained)
//   bus   : sram_responder_if.slave request/response bus
// A request accepted in idle is answered with a one-cycle resp_valid
// exactly LATENCY cycles later. Storage is written/read on the edge that
// enters the respond state; misaligned accesses only flag resp_err.
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    sram_responder_if.slave  bus
);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("sram_responder: LATENCY must be within 1..7");
    end

    sram_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        we_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              mis_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic              resp_rd_q;

    logic              accept;
    logic              go_resp;
    logic [3:0]        acc_we;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_wdata;
    logic              acc_mis;
    logic [3:0]        arr_we;
    logic              arr_re;
    logic [31:0]       arr_rdata;

    // Ready is gated by reset so nothing is accepted while reset is held.
    assign bus.req_ready = (state_q == StIdle) && !reset;
    assign accept        = bus.req && bus.req_ready;

    // With LATENCY == 1 the storage access happens on the acceptance edge,
    // so the live request fields are used instead of the captured copies.
    always_comb begin
        if (state_q == StIdle) begin
            acc_we    = bus.req_we;
            acc_idx   = bus.req_addr[ADDR_W+1:2];
            acc_wdata = bus.req_wdata;
            acc_mis   = is_misaligned(bus.req_addr[1:0]);
        end else begin
            acc_we    = we_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
            acc_mis   = mis_q;
        end
    end

    always_comb begin
        go_resp = 1'b0;
        if (state_q == StIdle && accept && LATENCY == 1) begin
            go_resp = 1'b1;
        end
        if (state_q == StWait && cnt_q == CNT_W'(1)) begin
            go_resp = 1'b1;
        end
    end

    assign arr_we = (go_resp && !acc_mis) ? acc_we : 4'b0000;
    assign arr_re = go_resp && !acc_mis && (acc_we == 4'b0000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            we_q         <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            mis_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rd_q    <= 1'b0;
        end else begin
            // Response flags are one-cycle pulses aligned with the respond state.
            resp_valid_q <= go_resp;
            resp_err_q   <= go_resp && acc_mis;
            resp_rd_q    <= go_resp && !acc_mis && (acc_we == 4'b0000);

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        we_q    <= acc_we;
                        idx_q   <= acc_idx;
                        wdata_q <= acc_wdata;
                        mis_q   <= acc_mis;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= (LATENCY == 1) ? StResp : StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    sram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rd_q ? arr_rdata : 32'h0;

endmodule
